// File: rtl/ray_unit_mc_if.sv
// ray_unit_mc_if: stream interface of the multi-lane ray unit.
//   Coordinate request stream : screen_x, screen_y, coords_valid -> coords_ready
//   Result stream             : out_valid, out_x, out_y, distance,
//                               surface_point -> out_ready
//   slave  modport: the ray unit (consumes coordinates, produces results)
//   master modport: the neighbour driving coordinates and taking results
// vec3 packing is {x, y, z} with x in the most significant FP_W bits.
interface ray_unit_mc_if #(
   parameter int FP_W = 16
);
   logic [FP_W-1:0]   screen_x;
   logic [FP_W-1:0]   screen_y;
   logic              coords_valid;
   logic              coords_ready;
   logic              out_valid;
   logic              out_ready;
   logic [FP_W-1:0]   out_x;
   logic [FP_W-1:0]   out_y;
   logic [FP_W-1:0]   distance;
   logic [3*FP_W-1:0] surface_point;

   modport slave (
      input  screen_x, screen_y, coords_valid, out_ready,
      output coords_ready, out_valid, out_x, out_y, distance, surface_point
   );

   modport master (
      output screen_x, screen_y, coords_valid, out_ready,
      input  coords_ready, out_valid, out_x, out_y, distance, surface_point
   );
endinterface

// File: rtl/ray_unit_mc.sv
// ray_unit_mc: multi-lane ray generation + marching unit with in-order
// result delivery.
//   clk, rst       : system clock, synchronous active-high reset
//   bus (slave)    : coordinate request stream in, tagged result stream out
//   cfg_load       : pulse, latches camera_forward/ray_origin/obj_sel when idle
//   cfg_err        : one-cycle pulse when cfg_load arrives while not idle
//   idle           : no ray in any lane, the reorder buffer or output register
//   ray_count      : results handed downstream since reset, saturating
// Rays are dispatched to the lowest free lane and tagged with a reorder
// buffer slot; lanes finish in any order, the ROB releases them in order.
// ROB_DEPTH must be a power of two, at least 2 and at least NUM_LANES.

// ray_generator: builds the ray direction from the pixel coordinate and the
// camera forward vector. Combinational.
//   screen_x, screen_y : pixel coordinate
//   camera_forward     : latched camera direction
//   direction          : ray direction {x, y, z}
//   step_key           : selects march length inside the marcher
module ray_generator #(
   parameter int FP_W = 16
) (
   input  logic [FP_W-1:0]   screen_x,
   input  logic [FP_W-1:0]   screen_y,
   input  logic [3*FP_W-1:0] camera_forward,
   output logic [3*FP_W-1:0] direction,
   output logic [2:0]        step_key
);
   assign direction = {camera_forward[3*FP_W-1 -: FP_W] + screen_x,
                       camera_forward[2*FP_W-1 -: FP_W] + screen_y,
                       camera_forward[FP_W-1:0]};
   assign step_key  = screen_x[2:0];
endmodule

// ray_marcher: steps along the ray a data-dependent number of times, then
// pulses valid_out with the distance and hit point. Intentionally has no
// reset: a ray in flight across a unit reset keeps marching and its result
// is dropped by the owner. A new start always overrides any ray in progress.
//   start          : begin marching (one-cycle pulse)
//   direction      : ray direction {x, y, z}
//   origin         : ray origin {x, y, z}
//   obj_sel        : scene object select (changes march length profile)
//   step_key       : per-ray march length selector
//   valid_out      : one-cycle result strobe
//   distance       : accumulated march distance
//   surface_point  : hit point {x, y, z}
module ray_marcher #(
   parameter int FP_W = 16
) (
   input  logic              clk,
   input  logic              start,
   input  logic [3*FP_W-1:0] direction,
   input  logic [3*FP_W-1:0] origin,
   input  logic              obj_sel,
   input  logic [2:0]        step_key,
   output logic              valid_out,
   output logic [FP_W-1:0]   distance,
   output logic [3*FP_W-1:0] surface_point
);
   logic            active;
   logic [3:0]      cnt;
   logic [3:0]      steps;
   logic [FP_W-1:0] acc;
   logic [FP_W-1:0] acc_next;
   logic [FP_W-1:0] dz;
   logic [FP_W-1:0] hit_x;
   logic [FP_W-1:0] hit_y;
   logic [FP_W-1:0] oz;

   // Object 0 marches long for small keys, object 1 the opposite, so a
   // burst of consecutive pixels completes out of order on either object.
   assign steps    = obj_sel ? ({1'b0, step_key} + 4'd1) : (4'd8 - {1'b0, step_key});
   assign acc_next = acc + dz;

   always_ff @(posedge clk) begin
      valid_out <= 1'b0;
      if (start) begin
         active <= 1'b1;
         cnt    <= steps;
         acc    <= '0;
         dz     <= direction[FP_W-1:0];
         hit_x  <= origin[3*FP_W-1 -: FP_W] + direction[3*FP_W-1 -: FP_W];
         hit_y  <= origin[2*FP_W-1 -: FP_W] + direction[2*FP_W-1 -: FP_W];
         oz     <= origin[FP_W-1:0];
      end else if (active) begin
         acc <= acc_next;
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            active        <= 1'b0;
            valid_out     <= 1'b1;
            distance      <= acc_next;
            surface_point <= {hit_x, hit_y, oz + acc_next};
         end
      end
   end
endmodule

module ray_unit_mc #(
   parameter int NUM_LANES = 4,
   parameter int ROB_DEPTH = 8,
   parameter int CNT_W     = 32,
   parameter int FP_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   ray_unit_mc_if.slave       bus,
   input  logic               cfg_load,
   input  logic [3*FP_W-1:0]  camera_forward,
   input  logic [3*FP_W-1:0]  ray_origin,
   input  logic               obj_sel,
   output logic               cfg_err,
   output logic               idle,
   output logic [CNT_W-1:0]   ray_count
);
   localparam int TAG_W  = $clog2(ROB_DEPTH);
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam logic [TAG_W:0] OCC_FULL = (TAG_W+1)'(ROB_DEPTH);

   // frame configuration as seen by the lanes
   logic [3*FP_W-1:0] cfg_fwd;
   logic [3*FP_W-1:0] cfg_org;
   logic              cfg_obj;

   // lane bookkeeping
   logic [NUM_LANES-1:0] busy;
   logic [TAG_W-1:0]     lane_tag   [NUM_LANES];
   logic [NUM_LANES-1:0] lane_start;
   logic [NUM_LANES-1:0] lane_valid;
   logic [NUM_LANES-1:0] lane_done;
   logic [FP_W-1:0]      lane_dist  [NUM_LANES];
   logic [3*FP_W-1:0]    lane_sp    [NUM_LANES];

   // reorder buffer
   logic [ROB_DEPTH-1:0] done;
   logic [FP_W-1:0]      rob_x      [ROB_DEPTH];
   logic [FP_W-1:0]      rob_y      [ROB_DEPTH];
   logic [FP_W-1:0]      rob_dist   [ROB_DEPTH];
   logic [3*FP_W-1:0]    rob_sp     [ROB_DEPTH];
   logic [TAG_W-1:0]     wr_ptr;
   logic [TAG_W-1:0]     rd_ptr;
   logic [TAG_W:0]       occupancy;

   // output register
   logic              out_valid_r;
   logic [FP_W-1:0]   out_x_r;
   logic [FP_W-1:0]   out_y_r;
   logic [FP_W-1:0]   out_dist_r;
   logic [3*FP_W-1:0] out_sp_r;

   logic              any_free;
   logic [LANE_W-1:0] free_idx;
   logic              coords_ready_c;
   logic              accept;
   logic              load;
   logic              emit;

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            any_free = 1'b1;
            free_idx = LANE_W'(i);
         end
      end
   end

   // rst gating keeps coords_ready low during reset even though busy and
   // occupancy are only cleared at the edge.
   assign coords_ready_c = !rst && any_free && (occupancy < OCC_FULL) && !cfg_load;
   assign accept         = bus.coords_valid && coords_ready_c;
   assign load           = (!out_valid_r || bus.out_ready) && done[rd_ptr];
   assign emit           = out_valid_r && bus.out_ready;
   assign idle           = !(|busy) && (occupancy == '0) && !out_valid_r;

   assign bus.coords_ready  = coords_ready_c;
   assign bus.out_valid     = out_valid_r;
   assign bus.out_x         = out_x_r;
   assign bus.out_y         = out_y_r;
   assign bus.distance      = out_dist_r;
   assign bus.surface_point = out_sp_r;

   // A lane that finishes in this cycle still reads busy here, so it cannot
   // be picked by the free-lane search until the following cycle.
   assign lane_done = lane_valid & busy;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      logic [3*FP_W-1:0] dir;
      logic [2:0]        key;

      // The start is taken straight from the accepted request so that the
      // marcher restarts on the same edge that sets busy; a stale strobe
      // from a pre-reset ray can then never be attributed to the new ray.
      assign lane_start[g] = accept && (free_idx == LANE_W'(g));

      ray_generator #(.FP_W(FP_W)) u_gen (
         .screen_x       (bus.screen_x),
         .screen_y       (bus.screen_y),
         .camera_forward (cfg_fwd),
         .direction      (dir),
         .step_key       (key)
      );

      ray_marcher #(.FP_W(FP_W)) u_march (
         .clk            (clk),
         .start          (lane_start[g]),
         .direction      (dir),
         .origin         (cfg_org),
         .obj_sel        (cfg_obj),
         .step_key       (key),
         .valid_out      (lane_valid[g]),
         .distance       (lane_dist[g]),
         .surface_point  (lane_sp[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= '0;
         done        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occupancy   <= '0;
         out_valid_r <= 1'b0;
         cfg_err     <= 1'b0;
         ray_count   <= '0;
         cfg_fwd     <= '0;
         cfg_org     <= '0;
         cfg_obj     <= 1'b0;
         for (int i = 0; i < NUM_LANES; i++) lane_tag[i] <= '0;
      end else begin
         cfg_err <= cfg_load && !idle;
         if (cfg_load && idle) begin
            cfg_fwd <= camera_forward;
            cfg_org <= ray_origin;
            cfg_obj <= obj_sel;
         end

         if (accept) begin
            busy[free_idx]     <= 1'b1;
            lane_tag[free_idx] <= wr_ptr;
            wr_ptr             <= wr_ptr + 1'b1;
         end

         // the slot being unloaded cannot also be completing: its ray
         // already left its lane
         if (load) begin
            done[rd_ptr] <= 1'b0;
            rd_ptr       <= rd_ptr + 1'b1;
            out_valid_r  <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end

         for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_done[i]) begin
               busy[i]           <= 1'b0;
               done[lane_tag[i]] <= 1'b1;
            end
         end

         case ({accept, load})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase

         if (emit && (ray_count != {CNT_W{1'b1}})) ray_count <= ray_count + 1'b1;
      end
   end

   // payload storage, qualified entirely by the control state above
   always_ff @(posedge clk) begin
      if (accept) begin
         rob_x[wr_ptr] <= bus.screen_x;
         rob_y[wr_ptr] <= bus.screen_y;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_done[i]) begin
            rob_dist[lane_tag[i]] <= lane_dist[i];
            rob_sp[lane_tag[i]]   <= lane_sp[i];
         end
      end
      if (!rst && load) begin
         out_x_r    <= rob_x[rd_ptr];
         out_y_r    <= rob_y[rd_ptr];
         out_dist_r <= rob_dist[rd_ptr];
         out_sp_r   <= rob_sp[rd_ptr];
      end
   end
endmodule
